// File: rtl/regwr_scheduler_if.sv
// Bundle of writeback request, register-file write port and issue-stage signals
// shared between the regwr_scheduler and the pipeline around it.
interface regwr_scheduler_if #(
  parameter int AW = 5,
  parameter int DW = 32
);
  logic          alu_valid;
  logic [AW-1:0] alu_reg;
  logic [DW-1:0] alu_data;
  logic          alu_ready;

  logic          ld_valid;
  logic [AW-1:0] ld_reg;
  logic [DW-1:0] ld_data;
  logic          ld_ready;

  logic          EnableWrite;
  logic [AW-1:0] write_reg;
  logic [DW-1:0] write_data;

  logic          issue_valid;
  logic          issue_wr;
  logic [AW-1:0] issue_dst;
  logic [AW-1:0] issue_src1;
  logic [AW-1:0] issue_src2;
  logic          issue_stall;

  // The pipeline side drives requests and the issue slot.
  modport master (
    output alu_valid, alu_reg, alu_data, ld_valid, ld_reg, ld_data,
    output issue_valid, issue_wr, issue_dst, issue_src1, issue_src2,
    input  alu_ready, ld_ready, EnableWrite, write_reg, write_data, issue_stall
  );

  modport slave (
    input  alu_valid, alu_reg, alu_data, ld_valid, ld_reg, ld_data,
    input  issue_valid, issue_wr, issue_dst, issue_src1, issue_src2,
    output alu_ready, ld_ready, EnableWrite, write_reg, write_data, issue_stall
  );
endinterface

// File: rtl/regwr_scheduler.sv
// Write-port arbiter and RAW/WAW scoreboard for the integer register file.
// Define REGWR_FIXED_PRIO_EN for fixed load-first arbitration instead of round-robin.
module regwr_scheduler #(
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input logic              clk,
  input logic              rst,
  regwr_scheduler_if.slave bus
);

  logic          alu_ready;
  logic          ld_ready;
  logic          alu_fire;
  logic          ld_fire;
  logic          en_write;
  logic [AW-1:0] wr_reg;
  logic [DW-1:0] wr_data;
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_next;
  logic          issue_set;
  logic          stall;

`ifdef REGWR_FIXED_PRIO_EN
  // Loads always win; the ALU only gets the port when no load is waiting.
  always_comb begin
    ld_ready  = 1'b1;
    alu_ready = !bus.ld_valid;
  end
`else
  typedef enum logic {
    GRANT_ALU = 1'b0,
    GRANT_LD  = 1'b1
  } grant_e;

  grant_e last_grant;
  logic   conflict;

  always_comb begin
    conflict  = bus.alu_valid && bus.ld_valid;
    alu_ready = !conflict || (last_grant == GRANT_LD);
    ld_ready  = !conflict || (last_grant == GRANT_ALU);
  end

  // Starting from LD makes the ALU the winner of the first conflict.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= GRANT_LD;
    end else if (alu_fire) begin
      last_grant <= GRANT_ALU;
    end else if (ld_fire) begin
      last_grant <= GRANT_LD;
    end
  end
`endif

  assign alu_fire = bus.alu_valid && alu_ready;
  assign ld_fire  = bus.ld_valid && ld_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_write <= 1'b0;
      wr_reg   <= '0;
      wr_data  <= '0;
    end else begin
      en_write <= alu_fire || ld_fire;
      if (ld_fire) begin
        wr_reg  <= bus.ld_reg;
        wr_data <= bus.ld_data;
      end else if (alu_fire) begin
        wr_reg  <= bus.alu_reg;
        wr_data <= bus.alu_data;
      end
    end
  end

  // The write cycle itself stalls issue because the file's read data is stale then.
  always_comb begin
    stall = bus.issue_valid && (busy[bus.issue_src1] || busy[bus.issue_src2] ||
                                (bus.issue_wr && busy[bus.issue_dst]) || en_write);
    issue_set = bus.issue_valid && bus.issue_wr && !stall;
  end

  // Clear is applied before set so a same-edge collision leaves the bit set.
  always_comb begin
    busy_next = busy;
    if (en_write) begin
      busy_next[wr_reg] = 1'b0;
    end
    if (issue_set) begin
      busy_next[bus.issue_dst] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

  assign bus.alu_ready   = alu_ready;
  assign bus.ld_ready    = ld_ready;
  assign bus.EnableWrite = en_write;
  assign bus.write_reg   = wr_reg;
  assign bus.write_data  = wr_data;
  assign bus.issue_stall = stall;

endmodule
